// File: rtl/count_toggle_multi.sv
// Multi-channel count-and-toggle generator: each channel counts enabled cycles up to
// a programmable limit, then toggles or pulses its output. Define COUNT_TOGGLE_SYNC_EN for i_Sync.

module count_toggle_ch #(
    parameter int CNT_WIDTH     = 24,
    parameter int DEFAULT_LIMIT = 10
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_Enable,
    input  logic                 i_Mode,
    input  logic                 i_Sync,
    input  logic                 i_Lim_Wr,
    input  logic [CNT_WIDTH-1:0] i_Lim_Val,
    output logic                 o_Toggle,
    output logic                 o_Wrap
);

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] limit;
    logic                 idle;
    logic                 terminal;

    // >= rather than == so a limit shrunk below the running count ends the period at once
    assign idle     = (limit == '0);
    assign terminal = (cnt >= limit - CNT_WIDTH'(1));

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L)
            limit <= CNT_WIDTH'(DEFAULT_LIMIT);
        else if (i_Lim_Wr)
            limit <= i_Lim_Val;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt      <= '0;
            o_Toggle <= 1'b0;
            o_Wrap   <= 1'b0;
        end else if (!i_Enable || idle) begin
            cnt      <= '0;
            o_Toggle <= 1'b0;
            o_Wrap   <= 1'b0;
        end else if (i_Sync) begin
            cnt    <= '0;
            o_Wrap <= 1'b0;
            if (i_Mode)
                o_Toggle <= 1'b0;
        end else if (terminal) begin
            cnt      <= '0;
            o_Wrap   <= 1'b1;
            o_Toggle <= i_Mode ? 1'b1 : ~o_Toggle;
        end else begin
            cnt    <= cnt + CNT_WIDTH'(1);
            o_Wrap <= 1'b0;
            if (i_Mode)
                o_Toggle <= 1'b0;
        end
    end

endmodule

module count_toggle_multi #(
    parameter int NUM_CH        = 4,
    parameter int CNT_WIDTH     = 24,
    parameter int DEFAULT_LIMIT = 10,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic [NUM_CH-1:0]    i_Enable,
    input  logic [NUM_CH-1:0]    i_Mode,
    input  logic                 i_Cfg_Wr,
    input  logic [CH_W-1:0]      i_Cfg_Ch,
    input  logic [CNT_WIDTH-1:0] i_Cfg_Limit,
`ifdef COUNT_TOGGLE_SYNC_EN
    input  logic                 i_Sync,
`endif
    output logic [NUM_CH-1:0]    o_Toggle,
    output logic [NUM_CH-1:0]    o_Wrap
);

    typedef struct packed {
        logic                 wr;
        logic [CH_W-1:0]      ch;
        logic [CNT_WIDTH-1:0] limit;
    } cfg_req_t;

    cfg_req_t          cfg;
    logic [NUM_CH-1:0] lim_wr;
    logic              sync;

    assign cfg = '{wr: i_Cfg_Wr, ch: i_Cfg_Ch, limit: i_Cfg_Limit};

`ifdef COUNT_TOGGLE_SYNC_EN
    assign sync = i_Sync;
`else
    assign sync = 1'b0;
`endif

    // Out-of-range channel numbers match no decode slot, so those writes fall on the floor
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign lim_wr[c] = cfg.wr && (cfg.ch == CH_W'(c));

        count_toggle_ch #(
            .CNT_WIDTH     (CNT_WIDTH),
            .DEFAULT_LIMIT (DEFAULT_LIMIT)
        ) u_ch (
            .i_Clk     (i_Clk),
            .i_Rst_L   (i_Rst_L),
            .i_Enable  (i_Enable[c]),
            .i_Mode    (i_Mode[c]),
            .i_Sync    (sync),
            .i_Lim_Wr  (lim_wr[c]),
            .i_Lim_Val (cfg.limit),
            .o_Toggle  (o_Toggle[c]),
            .o_Wrap    (o_Wrap[c])
        );
    end

endmodule

// File: tb/tb_count_toggle_multi.sv
// Directed bench for count_toggle_multi (4 channels, 24-bit counters, default limit 10).
module tb_count_toggle_multi;

    localparam int NUM_CH = 4;
    localparam int CW     = 24;

    logic          clk;
    logic          rst_n;
    logic [3:0]    en;
    logic [3:0]    mode;
    logic          cfg_wr;
    logic [1:0]    cfg_ch;
    logic [CW-1:0] cfg_lim;
    logic          sync;
    logic [3:0]    tog;
    logic [3:0]    wrap;

    int n_vec;
    int n_err;

    count_toggle_multi #(.NUM_CH(NUM_CH), .CNT_WIDTH(CW), .DEFAULT_LIMIT(10)) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_Enable    (en),
        .i_Mode      (mode),
        .i_Cfg_Wr    (cfg_wr),
        .i_Cfg_Ch    (cfg_ch),
        .i_Cfg_Limit (cfg_lim),
`ifdef COUNT_TOGGLE_SYNC_EN
        .i_Sync      (sync),
`endif
        .o_Toggle    (tog),
        .o_Wrap      (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [CW-1:0] lim);
        cfg_wr  = 1'b1;
        cfg_ch  = ch;
        cfg_lim = lim;
        step();
        cfg_wr  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = '0; mode = '0; cfg_wr = 0; cfg_ch = 0; cfg_lim = 0; sync = 0;
        repeat (2) step();
        n_vec++;
        if (tog !== 4'h0 || wrap !== 4'h0) begin
            n_err++; $display("FAIL reset_state tog=%h wrap=%h want 0/0", tog, wrap);
        end
        rst_n = 1'b1; en = 4'hF;
        repeat (12) step();
        n_vec++;
        if (tog !== 4'hF) begin
            n_err++; $display("FAIL pre_reset_toggle tog=%h want f", tog);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (tog !== 4'h0 || wrap !== 4'h0) begin
            n_err++; $display("FAIL async_reset tog=%h wrap=%h want 0/0", tog, wrap);
        end
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 9) begin
                n_vec++;
                if (tog !== 4'h0 || wrap !== 4'h0) begin
                    n_err++; $display("FAIL reset_edge9 tog=%h wrap=%h want 0/0", tog, wrap);
                end
            end
            if (k == 10) begin
                n_vec++;
                if (tog !== 4'hF || wrap !== 4'hF) begin
                    n_err++; $display("FAIL reset_edge10 tog=%h wrap=%h want f/f", tog, wrap);
                end
            end
        end
        en = '0;
        step();
    endtask

    task automatic test_toggle();
        int wraps;
        logic et, ew;
        wraps = 0;
        en = 4'b0001;
        for (int k = 1; k <= 100; k++) begin
            step();
            et = ((k / 10) % 2) == 1;
            ew = (k % 10) == 0;
            if (wrap[0] === 1'b1) wraps++;
            n_vec++;
            if (tog !== {3'b000, et} || wrap !== {3'b000, ew}) begin
                n_err++;
                $display("FAIL toggle_L10 edge=%0d tog=%h wrap=%h want %h/%h", k, tog, wrap, et, ew);
            end
        end
        n_vec++;
        if (wraps != 10) begin
            n_err++; $display("FAIL toggle_wrap_count got=%0d want 10", wraps);
        end
        en = '0;
        step();
    endtask

    task automatic test_pulse();
        logic e;
        cfg_write(2'd1, 24'd3);
        mode = 4'b0010; en = 4'b0010;
        for (int k = 1; k <= 9; k++) begin
            step();
            e = (k % 3) == 0;
            n_vec++;
            if (tog[1] !== e || wrap[1] !== e) begin
                n_err++; $display("FAIL pulse_L3 edge=%0d tog=%b wrap=%b want %b", k, tog[1], wrap[1], e);
            end
        end
        en = '0;
        step();
        cfg_write(2'd1, 24'd1);
        en = 4'b0010;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_vec++;
            if (tog[1] !== 1'b1 || wrap[1] !== 1'b1) begin
                n_err++; $display("FAIL pulse_L1 edge=%0d tog=%b wrap=%b want 1/1", k, tog[1], wrap[1]);
            end
        end
        mode = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            step();
            e = (k % 2) == 0;
            n_vec++;
            if (tog[1] !== e) begin
                n_err++; $display("FAIL toggle_L1 edge=%0d tog=%b want %b", k, tog[1], e);
            end
        end
        en = '0;
        step();
    endtask

    task automatic test_shrink();
        cfg_write(2'd2, 24'd100);
        en = 4'b0100;
        repeat (50) step();
        n_vec++;
        if (tog[2] !== 1'b0 || wrap[2] !== 1'b0) begin
            n_err++; $display("FAIL shrink_pre tog=%b wrap=%b want 0/0", tog[2], wrap[2]);
        end
        cfg_write(2'd2, 24'd20);
        n_vec++;
        if (wrap[2] !== 1'b0) begin
            n_err++; $display("FAIL shrink_write_edge wrap=%b want 0", wrap[2]);
        end
        step();
        n_vec++;
        if (tog[2] !== 1'b1 || wrap[2] !== 1'b1) begin
            n_err++; $display("FAIL shrink_terminal tog=%b wrap=%b want 1/1", tog[2], wrap[2]);
        end
        for (int k = 53; k <= 72; k++) begin
            step();
            n_vec++;
            if (wrap[2] !== (k == 72) || tog[2] !== (k != 72)) begin
                n_err++; $display("FAIL shrink_period edge=%0d tog=%b wrap=%b", k, tog[2], wrap[2]);
            end
        end
        en = '0;
        step();
    endtask

    task automatic test_disable();
        en = 4'b1000;
        repeat (17) step();
        n_vec++;
        if (tog[3] !== 1'b1) begin
            n_err++; $display("FAIL disable_pre tog=%b want 1", tog[3]);
        end
        en = '0;
        step();
        n_vec++;
        if (tog[3] !== 1'b0 || wrap[3] !== 1'b0) begin
            n_err++; $display("FAIL disable_clear tog=%b wrap=%b want 0/0", tog[3], wrap[3]);
        end
        en = 4'b1000;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_vec++;
            if (tog[3] !== (k == 10) || wrap[3] !== (k == 10)) begin
                n_err++; $display("FAIL reenable edge=%0d tog=%b wrap=%b", k, tog[3], wrap[3]);
            end
        end
        en = '0;
        step();
        cfg_write(2'd3, 24'd0);
        en = 4'b1000;
        for (int k = 1; k <= 25; k++) begin
            step();
            n_vec++;
            if (tog[3] !== 1'b0 || wrap[3] !== 1'b0) begin
                n_err++; $display("FAIL limit0 edge=%0d tog=%b wrap=%b want 0/0", k, tog[3], wrap[3]);
            end
        end
        en = '0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0] ew, et;
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_lim = 24'd4;
        step();
        cfg_ch = 2'd1; cfg_lim = 24'd6;
        step();
        cfg_wr = 1'b0;
        en = 4'b0011;
        for (int k = 1; k <= 12; k++) begin
            step();
            ew = {(k % 6) == 0, (k % 4) == 0};
            et = {((k / 6) % 2) == 1, ((k / 4) % 2) == 1};
            n_vec++;
            if (wrap[1:0] !== ew || tog[1:0] !== et) begin
                n_err++; $display("FAIL b2b edge=%0d tog=%b wrap=%b want %b/%b", k, tog[1:0], wrap[1:0], et, ew);
            end
        end
        en = '0;
        step();
        en = 4'b0001;
        repeat (5) step();
        cfg_write(2'd0, 24'd2);
        n_vec++;
        if (wrap[0] !== 1'b0) begin
            n_err++; $display("FAIL same_edge_old_limit wrap=%b want 0", wrap[0]);
        end
        for (int k = 7; k <= 9; k++) begin
            step();
            n_vec++;
            if (wrap[0] !== (k != 8)) begin
                n_err++; $display("FAIL new_limit edge=%0d wrap=%b want %b", k, wrap[0], k != 8);
            end
        end
        en = '0;
        step();
    endtask

`ifdef COUNT_TOGGLE_SYNC_EN
    task automatic test_sync();
        cfg_write(2'd0, 24'd4);
        cfg_write(2'd1, 24'd6);
        en = 4'b0011;
        repeat (5) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        n_vec++;
        if (wrap[1:0] !== 2'b00) begin
            n_err++; $display("FAIL sync_clear wrap=%b want 00", wrap[1:0]);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            n_vec++;
            if (wrap[1:0] !== {(k % 6) == 0, (k % 4) == 0}) begin
                n_err++; $display("FAIL sync_align edge=%0d wrap=%b", k, wrap[1:0]);
            end
        end
        en = '0;
        step();
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_toggle();
        test_pulse();
        test_shrink();
        test_disable();
        test_back_to_back();
`ifdef COUNT_TOGGLE_SYNC_EN
        test_sync();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
